// File: rtl/simmem_pkg.sv
// Shared simulated-memory types: read-data beat payload, ID count, burst length width, arbiter state.
package simmem_pkg;

    localparam int unsigned NumIds            = 4;
    localparam int unsigned MaxRBurstLenWidth = 3;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rdata_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } rdata_arb_state_e;

endpackage

// File: rtl/simmem_rr_picker.sv
// Round-robin picker: first requester at or after ptr_i, wrapping; one-hot grant.
// Purely combinational, zero latency; no backpressure of its own.
module simmem_rr_picker #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o
);

    localparam int unsigned W  = $clog2(N);
    localparam int unsigned W1 = W + 1;

    always_comb begin
        logic         found;
        logic [W:0]   sum;
        logic [W-1:0] idx;
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr_i} + W1'(off);
            if (sum >= W1'(N)) begin
                sum = sum - W1'(N);
            end
            idx = sum[W-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simmem_rdata_arbiter.sv
// Burst-locked round-robin arbiter of released read-data beats onto one registered output.
// Latency 1 cycle; a beat is taken only when the output register is empty or draining this cycle.
module simmem_rdata_arbiter
    import simmem_pkg::*;
#(
    parameter int unsigned NumPorts = simmem_pkg::NumIds,
    parameter int unsigned MaxBeats = 2 ** simmem_pkg::MaxRBurstLenWidth
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumPorts-1:0]         in_valid_i,
    input  logic [NumPorts-1:0]         in_last_i,
    input  rdata_t                      in_data_i [NumPorts],
    output logic [NumPorts-1:0]         in_ready_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output rdata_t                      out_data_o,
    output logic [$clog2(NumPorts)-1:0] out_port_o,
    output logic                        out_last_o,
    output logic                        lock_o
);

    localparam int unsigned PortW = $clog2(NumPorts);
    localparam int unsigned CntW  = $clog2(MaxBeats);
    localparam logic [PortW-1:0] LastPort = PortW'(NumPorts - 1);
    localparam logic [CntW-1:0]  CntMax   = CntW'(MaxBeats - 1);

    rdata_arb_state_e   state_q, state_d;
    logic [PortW-1:0]   lock_port_q, lock_port_d;
    logic [PortW-1:0]   rr_q, rr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               out_valid_q, out_last_q;
    logic [PortW-1:0]   out_port_q;
    rdata_t             out_data_q;

    logic [NumPorts-1:0] rr_gnt, lock_gnt, gnt_oh;
    logic [PortW-1:0]    gnt_idx;
    logic                can_capture, capture, last_eff;

    simmem_rr_picker #(.N(NumPorts)) u_rr_picker (
        .req_i (in_valid_i),
        .ptr_i (rr_q),
        .gnt_o (rr_gnt)
    );

    always_comb begin
        lock_gnt              = '0;
        lock_gnt[lock_port_q] = in_valid_i[lock_port_q];
        gnt_oh                = (state_q == ARB_LOCKED) ? lock_gnt : rr_gnt;
        can_capture           = !out_valid_q || out_ready_i;
        in_ready_o            = (rst_ni && can_capture) ? gnt_oh : '0;
        capture               = |in_ready_o;
        gnt_idx               = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (gnt_oh[i]) begin
                gnt_idx = PortW'(i);
            end
        end
        // A burst that hits the length cap is closed as if it carried last.
        last_eff = in_last_i[gnt_idx] || (cnt_q == CntMax);
    end

    always_comb begin
        state_d     = state_q;
        lock_port_d = lock_port_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        if (capture) begin
            if (last_eff) begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
                rr_d    = (gnt_idx == LastPort) ? '0 : gnt_idx + PortW'(1);
            end else begin
                state_d     = ARB_LOCKED;
                lock_port_d = gnt_idx;
                cnt_d       = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB_IDLE;
            lock_port_q <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_port_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            lock_port_q <= lock_port_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            if (capture) begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_data_i[gnt_idx];
                out_port_q  <= gnt_idx;
                out_last_q  <= last_eff;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_port_o  = out_port_q;
    assign out_last_o  = out_last_q;
    assign lock_o      = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_simmem_rdata_arbiter.sv
// Scoreboard bench for simmem_rdata_arbiter: per-port beat sources, expected output stream queue.
module tb_simmem_rdata_arbiter;
    import simmem_pkg::*;

    localparam int NP = 4;
    localparam int MB = 8;

    typedef struct packed {
        rdata_t d;
        logic   last;
    } src_beat_t;

    typedef struct packed {
        logic [1:0] port;
        rdata_t     d;
        logic       last;
    } exp_beat_t;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic [NP-1:0] in_valid = '0;
    logic [NP-1:0] in_last = '0;
    rdata_t        in_data [NP];
    logic [NP-1:0] in_ready;
    logic          out_valid;
    logic          out_ready = 1'b1;
    rdata_t        out_data;
    logic [1:0]    out_port;
    logic          out_last;
    logic          lock;

    src_beat_t src_q [NP][$];
    exp_beat_t exp_q [$];
    logic [NP-1:0] ir_s;
    logic          lock_s;
    int checks = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    simmem_rdata_arbiter #(.NumPorts(NP), .MaxBeats(MB)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid),
        .in_last_i   (in_last),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_port_o  (out_port),
        .out_last_o  (out_last),
        .lock_o      (lock)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic add_burst(input int port, input int nb, input logic src_last, input logic exp_last,
                             input logic [7:0] tag);
        src_beat_t s;
        exp_beat_t e;
        for (int b = 0; b < nb; b++) begin
            s.d.data = {tag, 8'(port), 8'(b), 8'hA5};
            s.d.resp = 2'(b);
            s.last   = (b == nb - 1) ? src_last : 1'b0;
            src_q[port].push_back(s);
            e.port = 2'(port);
            e.d    = s.d;
            e.last = (b == nb - 1) ? exp_last : 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Called just after a falling edge; samples #1 later, before the capturing rising edge.
    task automatic step();
        exp_beat_t e;
        src_beat_t dump;
        for (int p = 0; p < NP; p++) begin
            in_valid[p] = (src_q[p].size() > 0);
            in_data[p]  = in_valid[p] ? src_q[p][0].d : '0;
            in_last[p]  = in_valid[p] ? src_q[p][0].last : 1'b0;
        end
        #1;
        ir_s   = in_ready;
        lock_s = lock;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_beat", 64'(out_port), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_port", 64'(out_port), 64'(e.port));
                check_eq("out_data", 64'(out_data), 64'(e.d));
                check_eq("out_last", 64'(out_last), 64'(e.last));
            end
        end
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            if (ir_s[p] && src_q[p].size() > 0) dump = src_q[p].pop_front();
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget, output int steps);
        steps = 0;
        while (exp_q.size() > 0 && steps < budget) begin
            step();
            steps++;
        end
        check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        for (int p = 0; p < NP; p++) in_data[p] = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_lock", 64'(lock), 64'd0);
        check_eq("rst_out_port", 64'(out_port), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_out_last", 64'(out_last), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk);

        // Two 3-beat bursts, back to back at full rate.
        add_burst(0, 3, 1'b1, 1'b1, 8'h01);
        add_burst(2, 3, 1'b1, 1'b1, 8'h01);
        drain("t1", 40, n);
        check_eq("t1_cycles", 64'(n), 64'd7);
        // Pointer now at 3: port 3 beats port 1.
        add_burst(3, 1, 1'b1, 1'b1, 8'h02);
        add_burst(1, 1, 1'b1, 1'b1, 8'h02);
        drain("t1b", 20, n);

        // Port 3 waits behind a locked 4-beat burst from port 1.
        add_burst(1, 4, 1'b1, 1'b1, 8'h03);
        step();
        add_burst(3, 1, 1'b1, 1'b1, 8'h03);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("t2_rdy3_blocked", 64'(ir_s[3]), 64'd0);
            check_eq("t2_locked", 64'(lock_s), 64'd1);
        end
        step();
        check_eq("t2_rdy3_granted", 64'(ir_s[3]), 64'd1);
        drain("t2", 20, n);

        // Single-beat bursts on all ports: pure rotation, never locked.
        add_burst(0, 1, 1'b1, 1'b1, 8'h04);
        add_burst(1, 1, 1'b1, 1'b1, 8'h04);
        add_burst(2, 1, 1'b1, 1'b1, 8'h04);
        add_burst(3, 1, 1'b1, 1'b1, 8'h04);
        add_burst(0, 1, 1'b1, 1'b1, 8'h05);
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq("t3_nolock", 64'(lock_s), 64'd0);
        end
        check_eq("t3_drained", 64'(exp_q.size()), 64'd0);

        // Output stall for 5 cycles.
        add_burst(1, 2, 1'b1, 1'b1, 8'h06);
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("t4_valid", 64'(out_valid), 64'd1);
            check_eq("t4_data_hold", 64'(out_data), 64'(exp_q[0].d));
            check_eq("t4_port_hold", 64'(out_port), 64'(exp_q[0].port));
            check_eq("t4_rdy_zero", 64'(ir_s), 64'd0);
        end
        out_ready = 1'b1;
        drain("t4", 20, n);

        // Over-long burst without last is cut at MaxBeats; port 3 follows.
        add_burst(2, MB, 1'b0, 1'b1, 8'h07);
        add_burst(3, 1, 1'b1, 1'b1, 8'h07);
        drain("t5", 40, n);
        check_eq("t5_unlocked", 64'(lock), 64'd0);

        // Reset in the middle of a burst.
        add_burst(1, 4, 1'b1, 1'b1, 8'h08);
        step();
        step();
        rst_ni = 1'b0;
        #1;
        check_eq("t6_valid_drop", 64'(out_valid), 64'd0);
        check_eq("t6_lock_drop", 64'(lock), 64'd0);
        check_eq("t6_rdy_in_rst", 64'(in_ready), 64'd0);
        check_eq("t6_data_clr", 64'(out_data), 64'd0);
        for (int p = 0; p < NP; p++) src_q[p].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        add_burst(0, 1, 1'b1, 1'b1, 8'h09);
        add_burst(1, 1, 1'b1, 1'b1, 8'h09);
        drain("t6", 20, n);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time limit reached");
        $fatal(1);
    end

endmodule
